// File: rtl/router_merge_if.sv
// Stream bundle for the 4-to-1 merge: four input lanes with valid/ready plus one tagged output lane.
interface router_merge_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] din1;
  logic [DATA_WIDTH-1:0] din2;
  logic [DATA_WIDTH-1:0] din3;
  logic [3:0]            din_valid;
  logic [3:0]            din_ready;
  logic [DATA_WIDTH-1:0] dout;
  logic [1:0]            dout_addr;
  logic                  dout_valid;
  logic                  dout_ready;

  modport slave (
    input  din0, din1, din2, din3, din_valid, dout_ready,
    output din_ready, dout, dout_addr, dout_valid
  );

  modport master (
    output din0, din1, din2, din3, din_valid, dout_ready,
    input  din_ready, dout, dout_addr, dout_valid
  );
endinterface

// File: rtl/router_merge.sv
// 4-to-1 round-robin stream merge with a single registered output stage tagged by source port.
// Define ROUTER_MERGE_FIXED_PRIO_EN for fixed priority (port 0 highest) in place of round-robin.
module router_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          resetn,
  router_merge_if.slave bus
);
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [1:0]            addr_q, addr_d;
  logic                  valid_q, valid_d;
  logic                  out_free;
  logic                  grant_valid;
  logic [1:0]            grant_idx;
  logic [3:0]            din_ready_w;
  logic [DATA_WIDTH-1:0] din_arr [4];

  assign din_arr[0] = bus.din0;
  assign din_arr[1] = bus.din1;
  assign din_arr[2] = bus.din2;
  assign din_arr[3] = bus.din3;

  assign out_free = !valid_q || bus.dout_ready;

`ifdef ROUTER_MERGE_FIXED_PRIO_EN
  // Descending scan so the lowest-index requester is the one left standing.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (bus.din_valid[k]) begin
        grant_valid = 1'b1;
        grant_idx   = 2'(k);
      end
    end
  end
`else
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] search_idx;

  // Search starts just after the last granted port; the 2-bit index wraps naturally.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    search_idx  = ptr_q;
    for (int k = 0; k < 4; k++) begin
      search_idx = search_idx + 2'd1;
      if (!grant_valid && bus.din_valid[search_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = search_idx;
      end
    end
  end

  assign ptr_d = (out_free && grant_valid) ? grant_idx : ptr_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q <= 2'd3;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  for (genvar gi = 0; gi < 4; gi++) begin : g_ready
    assign din_ready_w[gi] = resetn && out_free && grant_valid && (grant_idx == 2'(gi));
  end
  assign bus.din_ready = din_ready_w;

  always_comb begin
    dout_d  = dout_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    if (out_free) begin
      valid_d = grant_valid;
      if (grant_valid) begin
        dout_d = din_arr[grant_idx];
        addr_d = grant_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout_q  <= '0;
      addr_q  <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_addr  = addr_q;
  assign bus.dout_valid = valid_q;
endmodule

// File: tb/tb_router_merge.sv
// Self-checking bench for router_merge: reset, vector table, hand-written corner sequences, random vs model.
module tb_router_merge;
  localparam int DW = 32;
`ifdef ROUTER_MERGE_FIXED_PRIO_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  router_merge_if #(.DATA_WIDTH(DW)) bus ();
  router_merge #(.DATA_WIDTH(DW)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] din_v [4];

  typedef struct {
    logic [3:0]    dv;
    logic          dr;
    logic [3:0]    exp_rdy;
    logic          exp_v;
    logic [1:0]    exp_addr;
    logic [DW-1:0] exp_dout;
  } vec_t;
  vec_t vecs [10];

  // Reference model state: registered output word and last-granted port.
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [1:0]    m_addr;
  int            m_ptr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] dv, input logic dr);
    @(negedge clk);
    bus.din0 = din_v[0];
    bus.din1 = din_v[1];
    bus.din2 = din_v[2];
    bus.din3 = din_v[3];
    bus.din_valid  = dv;
    bus.dout_ready = dr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    bus.din_valid = 4'b0000;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  function automatic int model_grant(input logic [3:0] dv, input logic dr);
    int p;
    if (m_valid && !dr) return -1;
    for (int k = 0; k < 4; k++) begin
      if (FP) p = k;
      else    p = (m_ptr + 1 + k) % 4;
      if (dv[p]) return p;
    end
    return -1;
  endfunction

  initial begin
    int cnt [4];
    int g;
    int in_cnt, out_cnt;
    logic [3:0] pend;
    logic [3:0] exp_rdy;
    logic dr;

    for (int i = 0; i < 4; i++) din_v[i] = 32'hDEAD_0000 | DW'(i);
    bus.din0 = din_v[0]; bus.din1 = din_v[1]; bus.din2 = din_v[2]; bus.din3 = din_v[3];
    bus.din_valid = 4'b1111;
    bus.dout_ready = 1'b1;

    // Reset state with every port requesting.
    #1 resetn = 1'b0;
    #1;
    check("rst_din_ready", bus.din_ready, 4'b0000);
    check("rst_dout_valid", bus.dout_valid, 1'b0);
    check("rst_dout", bus.dout, 32'h0);
    check("rst_dout_addr", bus.dout_addr, 2'd0);
    @(negedge clk);
    resetn = 1'b1;
    bus.din_valid = 4'b0000;

    vecs[0] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hC000_0000};
    vecs[1] = '{4'b1111, 1'b1, FP ? 4'b0001 : 4'b0010, 1'b1, FP ? 2'd0 : 2'd1, FP ? 32'hC000_0001 : 32'hC001_0001};
    vecs[2] = '{4'b1010, 1'b0, 4'b0000, 1'b1, FP ? 2'd0 : 2'd1, FP ? 32'hC000_0001 : 32'hC001_0001};
    vecs[3] = '{4'b1010, 1'b1, FP ? 4'b0010 : 4'b1000, 1'b1, FP ? 2'd1 : 2'd3, FP ? 32'hC001_0003 : 32'hC003_0003};
    vecs[4] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0};
    vecs[5] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0};
    vecs[6] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hC000_0006};
    vecs[7] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd0, 32'hC000_0006};
    vecs[8] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hC002_0008};
    vecs[9] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hC000_0009};

    foreach (vecs[r]) begin
      for (int i = 0; i < 4; i++) din_v[i] = 32'hC000_0000 | (DW'(i) << 16) | DW'(r);
      drive(vecs[r].dv, vecs[r].dr);
      check($sformatf("vec%0d_ready", r), bus.din_ready, vecs[r].exp_rdy);
      tick();
      check($sformatf("vec%0d_valid", r), bus.dout_valid, vecs[r].exp_v);
      if (vecs[r].exp_v) begin
        check($sformatf("vec%0d_addr", r), bus.dout_addr, vecs[r].exp_addr);
        check($sformatf("vec%0d_dout", r), bus.dout, vecs[r].exp_dout);
      end
      $display("vec %0d: dv=%b dr=%b ready=%b -> valid=%b addr=%0d dout=%08h",
               r, vecs[r].dv, vecs[r].dr, bus.din_ready, bus.dout_valid, bus.dout_addr, bus.dout);
    end

    // Single requester streams back-to-back.
    for (int k = 0; k < 8; k++) begin
      din_v[2] = 32'hA5A5_0000 + DW'(k);
      drive(4'b0100, 1'b1);
      check("single_ready", bus.din_ready, 4'b0100);
      tick();
      check("single_valid", bus.dout_valid, 1'b1);
      check("single_addr", bus.dout_addr, 2'd2);
      check("single_dout", bus.dout, 32'hA5A5_0000 + DW'(k));
      $display("single k=%0d dout=%08h addr=%0d", k, bus.dout, bus.dout_addr);
    end

    // Fairness with all four ports requesting.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      din_v[i] = 32'hF000_0000 | DW'(i);
      cnt[i] = 0;
    end
    for (int n = 0; n < 16; n++) begin
      drive(4'b1111, 1'b1);
      tick();
      check("rr_addr", bus.dout_addr, FP ? 2'd0 : 2'(n % 4));
      check("rr_dout", bus.dout, din_v[bus.dout_addr]);
      cnt[bus.dout_addr]++;
      $display("rr n=%0d addr=%0d", n, bus.dout_addr);
    end
    for (int p = 0; p < 4; p++)
      check($sformatf("rr_count%0d", p), cnt[p], FP ? ((p == 0) ? 16 : 0) : 4);

    // Backpressure holds the output and blocks every input.
    do_reset();
    din_v[0] = 32'h1234_5678;
    din_v[1] = 32'h1111_0001;
    din_v[3] = 32'h3333_0003;
    drive(4'b0001, 1'b1);
    check("bp_load_ready", bus.din_ready, 4'b0001);
    tick();
    for (int n = 0; n < 5; n++) begin
      drive(4'b1010, 1'b0);
      check("bp_ready", bus.din_ready, 4'b0000);
      check("bp_dout", bus.dout, 32'h1234_5678);
      check("bp_valid", bus.dout_valid, 1'b1);
      tick();
    end
    drive(4'b1010, 1'b1);
    check("bp_release_ready", bus.din_ready, 4'b0010);
    tick();
    check("bp_release_addr", bus.dout_addr, 2'd1);
    check("bp_release_dout", bus.dout, 32'h1111_0001);
    drive(4'b1010, 1'b1);
    check("bp_next_ready", bus.din_ready, FP ? 4'b0010 : 4'b1000);
    tick();
    check("bp_next_addr", bus.dout_addr, FP ? 2'd1 : 2'd3);
    $display("backpressure done addr=%0d dout=%08h", bus.dout_addr, bus.dout);

    // Idle cycles leave the pointer where the last transfer put it.
    do_reset();
    drive(4'b0010, 1'b1);
    check("idle_first_ready", bus.din_ready, 4'b0010);
    tick();
    for (int n = 0; n < 3; n++) begin
      drive(4'b0000, 1'b1);
      tick();
      check("idle_valid", bus.dout_valid, 1'b0);
    end
    drive(4'b1001, 1'b1);
    check("idle_ready", bus.din_ready, FP ? 4'b0001 : 4'b1000);
    tick();
    check("idle_addr", bus.dout_addr, FP ? 2'd0 : 2'd3);
    $display("idle done addr=%0d", bus.dout_addr);

    // Reset while a word is held clears outputs without a clock edge.
    do_reset();
    din_v[2] = 32'h2222_2222;
    drive(4'b0100, 1'b1);
    tick();
    check("mid_pre_valid", bus.dout_valid, 1'b1);
    check("mid_pre_addr", bus.dout_addr, 2'd2);
    #2;
    resetn = 1'b0;
    bus.din_valid = 4'b1111;
    #1;
    check("mid_valid", bus.dout_valid, 1'b0);
    check("mid_dout", bus.dout, 32'h0);
    check("mid_addr", bus.dout_addr, 2'd0);
    check("mid_ready", bus.din_ready, 4'b0000);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("mid_release_ready", bus.din_ready, 4'b0001);
    tick();
    check("mid_release_addr", bus.dout_addr, 2'd0);
    $display("mid-reset done addr=%0d", bus.dout_addr);

    // Random traffic against the reference model.
    do_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_addr  = 2'd0;
    m_ptr   = 3;
    pend    = 4'b0000;
    in_cnt  = 0;
    out_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          din_v[i] = $urandom;
        end
      end
      dr = ($urandom_range(0, 3) != 0);
      drive(pend, dr);
      g = model_grant(pend, dr);
      exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
      check("rand_ready", bus.din_ready, exp_rdy);
      check("rand_valid", bus.dout_valid, m_valid);
      if (m_valid) begin
        check("rand_addr", bus.dout_addr, m_addr);
        check("rand_dout", bus.dout, m_data);
      end
      if (bus.dout_valid && dr) begin
        out_cnt++;
        $display("rand xfer c=%0d port=%0d data=%08h", c, bus.dout_addr, bus.dout);
      end
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = din_v[g];
        m_addr  = 2'(g);
        m_ptr   = g;
        pend[g] = 1'b0;
        in_cnt++;
      end else if (!m_valid || dr) begin
        m_valid = 1'b0;
      end
      tick();
    end
    check("rand_word_count", out_cnt + int'(bus.dout_valid), in_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
